// File: rtl/shift_dispatcher_if.sv
// Bundles every signal of shift_dispatcher except clock and reset.
//   Command side : i_cmd_valid/o_cmd_ready handshake with direction, rotate,
//                  iterations and value.
//   Shift unit   : o_start pulse and operands out; i_finished/i_value back.
//   Result side  : o_result_valid/i_result_ready handshake with o_result_value.
//   Status       : o_busy, o_count (FIFO occupancy).
// Modport slave is the dispatcher; modport master is the surrounding logic
// (command producer, shift unit, result consumer).
interface shift_dispatcher_if #(
  parameter int N     = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_direction;
  logic          i_cmd_rotate;
  logic [N-1:0]  i_cmd_iterations;
  logic [N-1:0]  i_cmd_value;

  logic          o_start;
  logic          o_direction;
  logic          o_rotate;
  logic [N-1:0]  o_iterations;
  logic [N-1:0]  o_value;
  logic          i_finished;
  logic [N-1:0]  i_value;

  logic          o_result_valid;
  logic          i_result_ready;
  logic [N-1:0]  o_result_value;

  logic          o_busy;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_cmd_valid, i_cmd_direction, i_cmd_rotate, i_cmd_iterations,
           i_cmd_value, i_finished, i_value, i_result_ready,
    output o_cmd_ready, o_start, o_direction, o_rotate, o_iterations, o_value,
           o_result_valid, o_result_value, o_busy, o_count
  );

  modport master (
    output i_cmd_valid, i_cmd_direction, i_cmd_rotate, i_cmd_iterations,
           i_cmd_value, i_finished, i_value, i_result_ready,
    input  o_cmd_ready, o_start, o_direction, o_rotate, o_iterations, o_value,
           o_result_valid, o_result_value, o_busy, o_count
  );
endinterface

// File: rtl/shift_dispatcher.sv
// Queues shift commands in a DEPTH-entry FIFO and dispatches them one at a
// time to an external shift unit, then hands the unit's result out through a
// valid/ready handshake.
//   i_clock : sole clock, rising edge.
//   i_reset : asynchronous, active-low reset.
//   bus     : shift_dispatcher_if.slave (command, shift-unit, result, status).
// Operation sequence per command: IDLE (pop) -> ISSUE (o_start) -> ARM ->
// WAIT (until i_finished) -> DELIVER (until i_result_ready) -> IDLE.
module shift_dispatcher #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  shift_dispatcher_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 2 * N + 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    DELIVER
  } state_t;

  state_t        state;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  logic          start;
  logic          op_direction;
  logic          op_rotate;
  logic [N-1:0]  op_iterations;
  logic [N-1:0]  op_value;
  logic          result_valid;
  logic [N-1:0]  result_value;

  // Ready comes from the registered count only, so a full FIFO stays closed
  // even in a cycle where IDLE pops the head.
  assign bus.o_cmd_ready = (count < CW'(DEPTH));
  assign push            = bus.i_cmd_valid && bus.o_cmd_ready;
  assign pop             = (state == IDLE) && (count != '0);
  assign head            = mem[rd_ptr];

  assign bus.o_count        = count;
  assign bus.o_busy         = (state != IDLE) || (count != '0);
  assign bus.o_start        = start;
  assign bus.o_direction    = op_direction;
  assign bus.o_rotate       = op_rotate;
  assign bus.o_iterations   = op_iterations;
  assign bus.o_value        = op_value;
  assign bus.o_result_valid = result_valid;
  assign bus.o_result_value = result_value;

  // Storage needs no reset: an entry is only read while count says it is live.
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= {bus.i_cmd_direction, bus.i_cmd_rotate,
                      bus.i_cmd_iterations, bus.i_cmd_value};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      start         <= 1'b0;
      op_direction  <= 1'b0;
      op_rotate     <= 1'b0;
      op_iterations <= '0;
      op_value      <= '0;
      result_valid  <= 1'b0;
      result_value  <= '0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            {op_direction, op_rotate, op_iterations, op_value} <= head;
            start <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: state <= ARM;
        // A finished level left over from the previous operation may still
        // be present here, so ARM never samples it.
        ARM:   state <= WAIT;
        WAIT: begin
          if (bus.i_finished) begin
            result_value <= bus.i_value;
            result_valid <= 1'b1;
            state        <= DELIVER;
          end
        end
        DELIVER: begin
          if (bus.i_result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_dispatcher.sv
`timescale 1ns/1ps
module tb_shift_dispatcher;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_dispatcher_if #(.N(N), .DEPTH(DEPTH)) bus ();

  shift_dispatcher #(.N(N), .DEPTH(DEPTH)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [N-1:0] exp_q[$];
  logic         stale;
  logic [N-1:0] poison;
  int unsigned  model_cnt;
  int unsigned  gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of a shift: logical shifts drop bits (count >= N gives
  // zero), rotates wrap modulo N.
  function automatic logic [N-1:0] model_shift(input logic dir, input logic rot,
                                               input logic [N-1:0] it, input logic [N-1:0] v);
    logic [2*N-1:0] dbl;
    int unsigned    k;
    if (rot) begin
      k   = it % N;
      dbl = {v, v};
      if (dir) return dbl[k +: N];
      else     return dbl[N - k +: N];
    end
    if (it >= N) return '0;
    return dir ? (v >> it) : (v << it);
  endfunction

  // Shift unit: finished goes high 3 cycles after o_start and stays high
  // until the next start; in stale mode it is held high all the time.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_cnt      = 0;
      bus.i_finished = stale;
      bus.i_value    = '0;
    end else if (bus.o_start) begin
      model_cnt      = 3;
      bus.i_finished = stale;
      bus.i_value    = model_shift(bus.o_direction, bus.o_rotate, bus.o_iterations, bus.o_value);
    end else if (model_cnt != 0) begin
      model_cnt--;
      if (model_cnt == 0) bus.i_finished = 1'b1;
    end else if (stale) begin
      bus.i_finished = 1'b1;
      bus.i_value    = poison;
    end
  end

  // Start pulses must be at least 5 cycles apart.
  always @(negedge clk) begin
    if (!rst_n) gap = 100;
    else if (bus.o_start) begin
      check("start_gap", 32'(gap >= 5), 1);
      gap = 1;
    end else gap++;
  end

  task automatic drive_cmd(input logic d, input logic r, input logic [N-1:0] it, input logic [N-1:0] v);
    bus.i_cmd_valid      = 1'b1;
    bus.i_cmd_direction  = d;
    bus.i_cmd_rotate     = r;
    bus.i_cmd_iterations = it;
    bus.i_cmd_value      = v;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_start"}, bus.o_start, 0);
    check({tag, "_rvalid"}, bus.o_result_valid, 0);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_rvalue"}, bus.o_result_value, 0);
    check({tag, "_dir"}, bus.o_direction, 0);
    check({tag, "_rot"}, bus.o_rotate, 0);
    check({tag, "_iter"}, bus.o_iterations, 0);
    check({tag, "_value"}, bus.o_value, 0);
    check({tag, "_count"}, bus.o_count, 0);
    check({tag, "_ready"}, bus.o_cmd_ready, 1);
  endtask

  // Needs i_result_ready = 1; consumes one result and checks it against the queue.
  task automatic expect_result(input string tag, input int unsigned budget);
    for (int unsigned c = 0; c < budget; c++) begin
      if (bus.o_result_valid) begin
        if (exp_q.size() == 0) check({tag, "_unexpected"}, 1, 0);
        else check(tag, bus.o_result_value, exp_q.pop_front());
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [N-1:0] it, v;
    logic         d, r, seen;
    logic [5:0]   acc_pat;
    int unsigned  issued;

    rst_n = 1'b0;
    stale = 1'b0;
    poison = '0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_direction = 1'b0;
    bus.i_cmd_rotate = 1'b0;
    bus.i_cmd_iterations = '0;
    bus.i_cmd_value = '0;
    bus.i_result_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset("reset");

    // Single op, pushed on the first edge after reset release.
    rst_n = 1'b1;
    drive_cmd(1'b0, 1'b0, 4'd1, 4'b0011);
    exp_q.push_back(model_shift(1'b0, 1'b0, 4'd1, 4'b0011));
    @(negedge clk); bus.i_cmd_valid = 1'b0;
    check("t1_start_early", bus.o_start, 0);
    check("t1_count", bus.o_count, 1);
    check("t1_busy", bus.o_busy, 1);
    @(negedge clk);
    check("t1_start", bus.o_start, 1);
    check("t1_dir", bus.o_direction, 0);
    check("t1_rot", bus.o_rotate, 0);
    check("t1_iter", bus.o_iterations, 1);
    check("t1_value", bus.o_value, 4'b0011);
    @(negedge clk);
    check("t1_start_once", bus.o_start, 0);
    check("t1_arm_rvalid", bus.o_result_valid, 0);
    @(negedge clk); check("t1_wait1_rvalid", bus.o_result_valid, 0);
    @(negedge clk); check("t1_wait2_rvalid", bus.o_result_valid, 0);
    @(negedge clk);
    check("t1_rvalid", bus.o_result_valid, 1);
    check("t1_result", bus.o_result_value, 4'b0110);
    void'(exp_q.pop_front());
    @(negedge clk);
    check("t1_done_rvalid", bus.o_result_valid, 0);
    check("t1_done_busy", bus.o_busy, 0);

    // Back-pressure: six pushes, the sixth finds the FIFO full.
    bus.i_result_ready = 1'b0;
    acc_pat = 6'b011111;
    for (int unsigned k = 0; k < 6; k++) begin
      case (k)
        0: begin d = 0; r = 0; it = 4'd1; v = 4'b0011; end
        1: begin d = 1; r = 1; it = 4'd1; v = 4'b1001; end
        2: begin d = 0; r = 1; it = 4'd2; v = 4'b0110; end
        3: begin d = 1; r = 0; it = 4'd3; v = 4'b1000; end
        4: begin d = 0; r = 0; it = 4'd5; v = 4'b1111; end
        default: begin d = 1; r = 0; it = 4'd1; v = 4'b0100; end
      endcase
      drive_cmd(d, r, it, v);
      check($sformatf("bp_ready%0d", k), bus.o_cmd_ready, 32'(acc_pat[k]));
      if (acc_pat[k]) exp_q.push_back(model_shift(d, r, it, v));
      @(negedge clk);
    end
    bus.i_cmd_valid = 1'b0;
    check("bp_count_full", bus.o_count, 4);
    check("bp_ready_full", bus.o_cmd_ready, 0);
    repeat (8) @(negedge clk);
    check("bp_held_valid", bus.o_result_valid, 1);
    check("bp_held_value", bus.o_result_value, exp_q[0]);
    repeat (3) @(negedge clk);
    check("bp_still_valid", bus.o_result_valid, 1);
    check("bp_still_value", bus.o_result_value, exp_q[0]);
    check("bp_still_count", bus.o_count, 4);
    bus.i_result_ready = 1'b1;
    for (int unsigned k = 0; k < 5; k++) expect_result($sformatf("bp_res%0d", k), 20);

    // Full FIFO with a pop in the same cycle as a push attempt.
    bus.i_result_ready = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      d = 1'($urandom); r = 1'($urandom); it = 4'($urandom); v = 4'($urandom);
      drive_cmd(d, r, it, v);
      check($sformatf("full_ready%0d", k), bus.o_cmd_ready, 1);
      exp_q.push_back(model_shift(d, r, it, v));
      @(negedge clk);
    end
    bus.i_cmd_valid = 1'b0;
    seen = 1'b0;
    for (int unsigned c = 0; c < 20 && !seen; c++) begin
      if (bus.o_result_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("full_valid_seen", seen, 1);
    check("full_count", bus.o_count, 4);
    check("full_result", bus.o_result_value, exp_q.pop_front());
    bus.i_result_ready = 1'b1;
    drive_cmd(1'b0, 1'b0, 4'd1, 4'b0001);
    @(negedge clk);
    check("full_pop_ready", bus.o_cmd_ready, 0);
    check("full_pop_count", bus.o_count, 4);
    bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    check("full_after_count", bus.o_count, 3);
    check("full_after_ready", bus.o_cmd_ready, 1);
    for (int unsigned k = 0; k < 4; k++) expect_result($sformatf("full_res%0d", k), 20);
    check("full_no_extra", 32'(exp_q.size()), 0);
    repeat (4) @(negedge clk);
    check("full_idle_busy", bus.o_busy, 0);

    // Stale finished held high: capture only on the first WAIT cycle.
    stale = 1'b1;
    poison = ~model_shift(1'b0, 1'b0, 4'd1, 4'b0011);
    repeat (2) @(negedge clk);
    drive_cmd(1'b0, 1'b0, 4'd1, 4'b0011);
    @(negedge clk); bus.i_cmd_valid = 1'b0;
    @(negedge clk); check("stale_start", bus.o_start, 1);
    @(negedge clk); check("stale_issue_cap", bus.o_result_valid, 0);
    @(negedge clk); check("stale_arm_cap", bus.o_result_valid, 0);
    @(negedge clk);
    check("stale_wait_cap", bus.o_result_valid, 1);
    check("stale_result", bus.o_result_value, 4'b0110);
    @(negedge clk);
    stale = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in WAIT with two commands queued.
    for (int unsigned k = 0; k < 3; k++) begin
      drive_cmd(1'b1, 1'b0, 4'(k + 2), 4'b1100);
      @(negedge clk);
    end
    bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    check("mr_count", bus.o_count, 2);
    check("mr_iter", bus.o_iterations, 2);
    check("mr_busy", bus.o_busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_result_valid || bus.o_start) seen = 1'b1;
    end
    check("mr_no_activity", seen, 0);
    check("mr_count_after", bus.o_count, 0);
    drive_cmd(1'b1, 1'b0, 4'd2, 4'b1100);
    exp_q.push_back(model_shift(1'b1, 1'b0, 4'd2, 4'b1100));
    @(negedge clk); bus.i_cmd_valid = 1'b0;
    expect_result("mr_new_result", 20);

    // Zero iterations forwarded unchanged.
    drive_cmd(1'b1, 1'b1, 4'd0, 4'b1010);
    exp_q.push_back(4'b1010);
    @(negedge clk); bus.i_cmd_valid = 1'b0;
    seen = 1'b0;
    for (int unsigned c = 0; c < 10 && !seen; c++) begin
      if (bus.o_start) seen = 1'b1;
      else @(negedge clk);
    end
    check("z_start_seen", seen, 1);
    check("z_iter", bus.o_iterations, 0);
    check("z_dir", bus.o_direction, 1);
    check("z_rot", bus.o_rotate, 1);
    check("z_value", bus.o_value, 4'b1010);
    expect_result("z_result", 20);

    // Random traffic against the queue model.
    issued = 0;
    for (int unsigned cyc = 0; cyc < 4000 && !(issued >= 40 && exp_q.size() == 0); cyc++) begin
      bus.i_cmd_valid      = (issued < 40) && ($urandom_range(0, 2) != 0);
      bus.i_cmd_direction  = 1'($urandom);
      bus.i_cmd_rotate     = 1'($urandom);
      bus.i_cmd_iterations = 4'($urandom);
      bus.i_cmd_value      = 4'($urandom);
      bus.i_result_ready   = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.o_result_valid && bus.i_result_ready) begin
        if (exp_q.size() == 0) check("rnd_unexpected", 1, 0);
        else check("rnd_result", bus.o_result_value, exp_q.pop_front());
      end
      if (bus.i_cmd_valid && bus.o_cmd_ready) begin
        exp_q.push_back(model_shift(bus.i_cmd_direction, bus.i_cmd_rotate,
                                    bus.i_cmd_iterations, bus.i_cmd_value));
        issued++;
      end
      @(negedge clk);
    end
    bus.i_cmd_valid = 1'b0;
    check("rnd_issued", issued, 40);
    check("rnd_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
